// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU forward/backward column arrays.
package relu_pkg;

   localparam int unsigned RELU_SYS_COL    = 16;
   localparam int unsigned RELU_DATA_WIDTH = 32;
   localparam int unsigned RELU_DEPTH      = 64;
   // Extra MSB is the wrap bit that tells full apart from empty.
   localparam int unsigned RELU_PTR_W      = $clog2(RELU_DEPTH) + 1;

   typedef logic [RELU_SYS_COL-1:0] relu_mask_t;
   typedef logic [RELU_SYS_COL-1:0][RELU_DATA_WIDTH-1:0] relu_row_t;

   // Derivative mask of one pre-activation row. The derivative at exactly 0 is 0.
   // A disabled row passes every lane through.
   function automatic relu_mask_t relu_mask(input relu_row_t row, input logic en);
      relu_mask_t m;
      for (int i = 0; i < int'(RELU_SYS_COL); i++) begin
         m[i] = en ? ($signed(row[i]) > 0) : 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Synchronous FIFO of derivative masks with wrap-bit pointers and a synchronous flush.
module relu_mask_fifo
   import relu_pkg::*;
#(
   parameter int unsigned DEPTH = RELU_DEPTH,
   parameter int unsigned WIDTH = RELU_SYS_COL,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned PW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    occupancy
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic             do_push;
   logic             do_pop;

   assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign empty     = (wr_q == rd_q);
   assign occupancy = wr_q - rd_q;
   assign rdata     = mem_q[rd_q[AW-1:0]];

   // Flush wins over both push and pop.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Pointer update; increments wrap modulo 2*DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
      end
   end

   // Mask storage; contents are don't-care while outside the pointer window.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/relu_bwd_arr.sv
// Backward ReLU column array: records derivative masks on the forward pass and
// gates gradient rows with them, in FIFO order, on the backward pass.
module relu_bwd_arr
   import relu_pkg::*;
#(
   parameter int unsigned SYS_COL    = RELU_SYS_COL,
   parameter int unsigned DATA_WIDTH = RELU_DATA_WIDTH,
   parameter int unsigned DEPTH      = RELU_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  fwd_en,
   input  logic                  fwd_valid,
   output logic                  fwd_ready,
   input  logic [DATA_WIDTH-1:0] fwd_act [0:SYS_COL-1],
   input  logic                  bwd_in_valid,
   output logic                  bwd_in_ready,
   input  logic [DATA_WIDTH-1:0] grad_in [0:SYS_COL-1],
   output logic                  bwd_out_valid,
   input  logic                  bwd_out_ready,
   output logic [DATA_WIDTH-1:0] grad_out [0:SYS_COL-1],
   output logic [$clog2(DEPTH):0] occupancy
);

   relu_row_t  fwd_row;
   relu_mask_t push_mask;
   relu_mask_t pop_mask;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic       out_valid_q;

   // Pack the forward row and derive its mask.
   always_comb begin
      fwd_row = '0;
      for (int i = 0; i < int'(SYS_COL); i++) begin
         fwd_row[i] = fwd_act[i];
      end
      push_mask = relu_mask(fwd_row, fwd_en);
   end

   // Handshakes depend only on registered state plus the downstream ready.
   assign fwd_ready     = !full;
   assign bwd_in_ready  = !empty && (!out_valid_q || bwd_out_ready);
   assign push          = fwd_valid && fwd_ready;
   assign pop           = bwd_in_valid && bwd_in_ready;
   assign bwd_out_valid = out_valid_q;

   relu_mask_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SYS_COL)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .wdata     (push_mask),
      .pop       (pop),
      .rdata     (pop_mask),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy)
   );

   // Output stage: load the gated row on a pop, hold while stalled, keep data on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         for (int i = 0; i < int'(SYS_COL); i++) begin
            grad_out[i] <= '0;
         end
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         for (int i = 0; i < int'(SYS_COL); i++) begin
            grad_out[i] <= pop_mask[i] ? grad_in[i] : '0;
         end
      end else if (bwd_out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_relu_bwd_arr.sv
// Directed and randomised bench for relu_bwd_arr with a mask/row scoreboard.
module tb_relu_bwd_arr;

   localparam int SC = 16;
   localparam int DW = 32;
   localparam int DP = 64;
   localparam int W  = SC * DW;

   typedef logic [SC-1:0][DW-1:0] row_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          fwd_en = 1'b0;
   logic          fwd_valid = 1'b0;
   logic          fwd_ready;
   logic [DW-1:0] fwd_act [0:SC-1];
   logic          bwd_in_valid = 1'b0;
   logic          bwd_in_ready;
   logic [DW-1:0] grad_in [0:SC-1];
   logic          bwd_out_valid;
   logic          bwd_out_ready = 1'b0;
   logic [DW-1:0] grad_out [0:SC-1];
   logic [$clog2(DP):0] occupancy;

   int checks = 0;
   int errors = 0;
   int n_push = 0;
   int n_out  = 0;

   // Reference model state.
   logic [SC-1:0] mq[$];
   row_t          eq[$];
   logic          m_ov = 1'b0;
   row_t          m_go = '0;

   always #5 clk = ~clk;

   relu_bwd_arr #(
      .SYS_COL    (SC),
      .DATA_WIDTH (DW),
      .DEPTH      (DP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .fwd_en        (fwd_en),
      .fwd_valid     (fwd_valid),
      .fwd_ready     (fwd_ready),
      .fwd_act       (fwd_act),
      .bwd_in_valid  (bwd_in_valid),
      .bwd_in_ready  (bwd_in_ready),
      .grad_in       (grad_in),
      .bwd_out_valid (bwd_out_valid),
      .bwd_out_ready (bwd_out_ready),
      .grad_out      (grad_out),
      .occupancy     (occupancy)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SC-1:0] tb_mask();
      logic [SC-1:0] m;
      for (int i = 0; i < SC; i++) begin
         m[i] = !fwd_en || (!fwd_act[i][DW-1] && (fwd_act[i] != '0));
      end
      return m;
   endfunction

   task automatic rand_acts();
      for (int i = 0; i < SC; i++) begin
         fwd_act[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      end
   endtask

   task automatic rand_grads();
      for (int i = 0; i < SC; i++) grad_in[i] = DW'($urandom);
   endtask

   task automatic model_reset();
      mq.delete();
      eq.delete();
      m_ov = 1'b0;
      m_go = '0;
   endtask

   // One clock: compare DUT against the model mid-cycle, then advance the model.
   task automatic tick();
      row_t          go;
      row_t          r;
      logic [SC-1:0] m;
      logic          exp_in_rdy;
      logic          do_push;
      logic          do_pop;
      @(negedge clk);
      for (int i = 0; i < SC; i++) go[i] = grad_out[i];
      exp_in_rdy = (mq.size() != 0) && (!m_ov || bwd_out_ready);
      chk("occupancy", W'(occupancy), W'(mq.size()));
      chk("fwd_ready", W'(fwd_ready), W'(mq.size() < DP));
      chk("bwd_in_ready", W'(bwd_in_ready), W'(exp_in_rdy));
      chk("bwd_out_valid", W'(bwd_out_valid), W'(m_ov));
      chk("grad_out", go, m_go);
      do_push = fwd_valid && (mq.size() < DP);
      do_pop  = bwd_in_valid && exp_in_rdy;
      if (flush) begin
         mq.delete();
         eq.delete();
         m_ov = 1'b0;
      end else begin
         if (m_ov && bwd_out_ready) begin
            chk("sb_nonempty", W'(eq.size() != 0), W'(1));
            if (eq.size() != 0) begin
               chk("sb_row", go, eq.pop_front());
               n_out++;
            end
         end
         if (do_pop) begin
            m = mq.pop_front();
            for (int i = 0; i < SC; i++) r[i] = m[i] ? grad_in[i] : '0;
            eq.push_back(r);
            m_go = r;
            m_ov = 1'b1;
         end else if (bwd_out_ready) begin
            m_ov = 1'b0;
         end
         if (do_push) begin
            mq.push_back(tb_mask());
            n_push++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pat [4] = '{5, -3, 0, 7};
      int push_start;
      int out_start;
      int cyc;

      for (int i = 0; i < SC; i++) begin
         fwd_act[i] = '0;
         grad_in[i] = '0;
      end

      // Reset values while rst_n is held low.
      #12;
      chk("rst_occupancy", W'(occupancy), W'(0));
      chk("rst_fwd_ready", W'(fwd_ready), W'(1));
      chk("rst_bwd_in_ready", W'(bwd_in_ready), W'(0));
      chk("rst_bwd_out_valid", W'(bwd_out_valid), W'(0));
      chk("rst_grad_out0", W'(grad_out[0]), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pattern row with ReLU enabled, gradient 0x10 everywhere.
      fwd_en = 1'b1;
      for (int i = 0; i < SC; i++) fwd_act[i] = pat[i % 4];
      fwd_valid = 1'b1;
      tick();
      fwd_valid = 1'b0;
      for (int i = 0; i < SC; i++) grad_in[i] = 32'h10;
      bwd_in_valid  = 1'b1;
      bwd_out_ready = 1'b1;
      tick();
      bwd_in_valid = 1'b0;
      chk("tp1_valid", W'(bwd_out_valid), W'(1));
      chk("tp1_lane0", W'(grad_out[0]), W'(32'h10));
      chk("tp1_lane1", W'(grad_out[1]), W'(0));
      chk("tp1_lane2", W'(grad_out[2]), W'(0));
      chk("tp1_lane3", W'(grad_out[3]), W'(32'h10));
      tick();

      // Pass-through row: negative acts with fwd_en low keep every lane.
      fwd_en = 1'b0;
      for (int i = 0; i < SC; i++) fwd_act[i] = -(i + 1);
      fwd_valid = 1'b1;
      tick();
      fwd_valid = 1'b0;
      for (int i = 0; i < SC; i++) grad_in[i] = i + 1;
      bwd_in_valid = 1'b1;
      tick();
      bwd_in_valid = 1'b0;
      chk("tp2_lane0", W'(grad_out[0]), W'(1));
      chk("tp2_lane15", W'(grad_out[15]), W'(16));
      tick();

      // Fill to full with fwd_valid held, then drain in order.
      fwd_en    = 1'b1;
      fwd_valid = 1'b1;
      repeat (DP + 1) begin
         rand_acts();
         tick();
      end
      fwd_valid = 1'b0;
      chk("full_occupancy", W'(occupancy), W'(DP));
      chk("full_fwd_ready", W'(fwd_ready), W'(0));
      bwd_in_valid = 1'b1;
      repeat (DP + 2) begin
         rand_grads();
         tick();
      end
      bwd_in_valid = 1'b0;
      tick();
      chk("drain_occupancy", W'(occupancy), W'(0));

      // Empty FIFO stalls gradients; one push makes the next cycle accept.
      bwd_in_valid = 1'b1;
      rand_grads();
      repeat (3) tick();
      rand_acts();
      fwd_valid = 1'b1;
      tick();
      fwd_valid = 1'b0;
      tick();
      chk("empty_then_accept", W'(bwd_out_valid), W'(1));
      bwd_in_valid = 1'b0;
      tick();

      // Output hold under backpressure.
      fwd_valid = 1'b1;
      repeat (2) begin
         rand_acts();
         tick();
      end
      fwd_valid     = 1'b0;
      bwd_out_ready = 1'b0;
      bwd_in_valid  = 1'b1;
      rand_grads();
      tick();
      repeat (5) begin
         rand_grads();
         tick();
      end
      bwd_out_ready = 1'b1;
      repeat (3) tick();
      bwd_in_valid = 1'b0;
      tick();

      // Random valid/ready traffic over 1000 rows.
      push_start = n_push;
      out_start  = n_out;
      cyc        = 0;
      while ((n_push - push_start) < 1000 && cyc < 20000) begin
         fwd_en        = ($urandom_range(0, 3) != 0);
         fwd_valid     = 1'($urandom_range(0, 1));
         bwd_in_valid  = 1'($urandom_range(0, 1));
         bwd_out_ready = ($urandom_range(0, 3) != 0);
         rand_acts();
         rand_grads();
         tick();
         cyc++;
      end
      fwd_valid     = 1'b0;
      bwd_in_valid  = 1'b1;
      bwd_out_ready = 1'b1;
      cyc = 0;
      while ((mq.size() != 0 || m_ov) && cyc < 300) begin
         rand_grads();
         tick();
         cyc++;
      end
      bwd_in_valid = 1'b0;
      tick();
      chk("rand_pushed", W'(n_push - push_start), W'(1000));
      chk("rand_delivered", W'(n_out - out_start), W'(1000));
      chk("rand_occupancy", W'(occupancy), W'(0));

      // Flush at occupancy 10 with a pending output and a simultaneous push.
      fwd_valid = 1'b1;
      repeat (11) begin
         rand_acts();
         tick();
      end
      fwd_valid     = 1'b0;
      bwd_out_ready = 1'b0;
      bwd_in_valid  = 1'b1;
      rand_grads();
      tick();
      bwd_in_valid = 1'b0;
      chk("pre_flush_occupancy", W'(occupancy), W'(10));
      flush     = 1'b1;
      fwd_valid = 1'b1;
      rand_acts();
      tick();
      flush     = 1'b0;
      fwd_valid = 1'b0;
      chk("flush_occupancy", W'(occupancy), W'(0));
      chk("flush_valid", W'(bwd_out_valid), W'(0));
      bwd_out_ready = 1'b1;
      repeat (2) tick();

      // Asynchronous reset mid-stream.
      fwd_valid = 1'b1;
      repeat (4) begin
         rand_acts();
         tick();
      end
      fwd_valid     = 1'b0;
      bwd_out_ready = 1'b0;
      bwd_in_valid  = 1'b1;
      rand_grads();
      tick();
      bwd_in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_occupancy", W'(occupancy), W'(0));
      chk("arst_valid", W'(bwd_out_valid), W'(0));
      chk("arst_grad_out0", W'(grad_out[0]), W'(0));
      chk("arst_fwd_ready", W'(fwd_ready), W'(1));
      chk("arst_bwd_in_ready", W'(bwd_in_ready), W'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bwd_out_ready = 1'b1;
      fwd_valid     = 1'b1;
      rand_acts();
      tick();
      fwd_valid    = 1'b0;
      bwd_in_valid = 1'b1;
      rand_grads();
      tick();
      bwd_in_valid = 1'b0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/relu_bwd_arr.md
Name: relu_bwd_arr

Overview:
- Backward-pass counterpart of the forward ReLU column array.
- During the forward pass it captures one SYS_COL-bit derivative mask per row of pre-activation values.
- During the backward pass it pops the masks in FIFO order and gates the incoming gradient rows: grad_out = grad_in where the mask bit is 1, else 0.
- Sits between the systolic array column outputs (forward) and the gradient datapath (backward), with a valid/ready handshake on all three streams.

Parameters:
- SYS_COL, 16, number of columns (lanes) per row.
- DATA_WIDTH, 32, width of activation and gradient words, two's complement.
- DEPTH, 64, mask FIFO depth in rows; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO and output stage.
- fwd_en  input  1  forward ReLU enabled for this row; 0 = pass-through row.
- fwd_valid  input  1  forward row valid.
- fwd_ready  output  1  mask FIFO can accept a row.
- fwd_act  input  DATA_WIDTH x SYS_COL  pre-activation row (unpacked array [0:SYS_COL-1]).
- bwd_in_valid  input  1  gradient row valid.
- bwd_in_ready  output  1  gradient row accepted.
- grad_in  input  DATA_WIDTH x SYS_COL  incoming gradient row.
- bwd_out_valid  output  1  masked gradient row valid.
- bwd_out_ready  input  1  downstream accepts masked row.
- grad_out  output  DATA_WIDTH x SYS_COL  masked gradient row, registered.
- occupancy  output  $clog2(DEPTH)+1  rows currently stored.

Behaviour:
- Reset (rst_n low, async): read/write pointers = 0, occupancy = 0, bwd_out_valid = 0, grad_out all 0. fwd_ready is then 1 and bwd_in_ready is 0.
- Mask generation: bit i = fwd_en ? ($signed(fwd_act[i]) > 0) : 1. Zero and negative values give 0; the derivative at 0 is defined as 0.
- FIFO pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - full when the pointer LSBs are equal and the MSBs differ; empty when the pointers are equal.
- Push: fwd_valid && fwd_ready. fwd_ready = !full, combinational from registered state only.
- bwd_in_ready = !empty && (!bwd_out_valid || bwd_out_ready).
- Pop: bwd_in_valid && bwd_in_ready. On the next edge: grad_out[i] = mask[i] ? grad_in[i] : 0, and bwd_out_valid = 1.
- Latency: one cycle from gradient acceptance to bwd_out_valid. Throughput is one row per cycle under continuous ready.
- Output hold: while bwd_out_valid && !bwd_out_ready, grad_out and bwd_out_valid are held stable. When bwd_out_ready is high and no pop occurs, bwd_out_valid clears.
- No bypass: a mask pushed in cycle N is poppable from cycle N+1 onward. Push and pop can occur in the same cycle, in which case occupancy is unchanged.
- Full: fwd_ready = 0 and fwd rows stall. A pop in the same cycle does not raise fwd_ready until the next cycle.
- Empty: bwd_in_ready = 0 and gradient rows stall; no underflow is possible.
- Wrap-around: pointers increment modulo 2*DEPTH, with correct full/empty across the wrap.
- flush has priority over push and pop in the same cycle. It clears pointers, occupancy and bwd_out_valid; grad_out keeps its value.
- Async reset mid-transfer drops all stored masks and the pending output row immediately.
- occupancy = write pointer - read pointer, modulo 2*DEPTH.

Decomposition:
- Package relu_pkg holds:
  - typedef relu_mask_t (logic [SYS_COL-1:0]);
  - function relu_mask(row, en), shared with forward-side checking;
  - a localparam for pointer width.
- One sub-module, relu_mask_fifo: parameterised DEPTH x SYS_COL synchronous FIFO with full/empty/occupancy and flush.
  - The top level holds the mask generation, the gating and the output register.

Test Plan:
- Reset, then push rows with act = {5, -3, 0, 7, ...} and fwd_en=1; send grad_in all 0x00000010 -> grad_out = {0x10, 0, 0, 0x10, ...}, one cycle after acceptance.
- Push with fwd_en=0 and all-negative acts, then pop with grad_in = i+1 per lane -> grad_out = i+1 for every lane.
- Push 64 rows with fwd_valid held high -> fwd_ready drops after the 64th push and occupancy = 64. Then pop 64 rows -> masks return in order across the pointer wrap, and occupancy returns to 0.
- With the FIFO empty, hold bwd_in_valid=1 -> bwd_in_ready stays 0 and bwd_out_valid stays 0. Push one row -> the gradient is accepted the following cycle.
- Hold bwd_out_ready=0 for 5 cycles after an output appears -> grad_out stays stable and bwd_in_ready = 0. Random ready/valid toggling over 1000 rows -> output matches the reference model with no loss or duplication.
- Assert flush at occupancy 10 with a pending output, simultaneous with a push -> next cycle occupancy = 0, bwd_out_valid = 0, and the push is dropped. Async rst_n pulse mid-stream -> all outputs return to their reset values immediately.
